// File: rtl/_regfile32.sv
// 32 x n register file: two combinational read ports with write-through bypass,
// one synchronous write port, and a per-register pending scoreboard for decode stalls.

module _mux32 #(
    parameter int n = 32
) (
    input  logic [32*n-1:0] i_data,
    input  logic [4:0]      i_sel,
    output logic [n-1:0]    o_data
);

    always_comb begin
        o_data = '0;
        for (int i = 0; i < 32; i++) begin
            if (i_sel == 5'(i)) begin
                o_data = i_data[i*n +: n];
            end
        end
    end

endmodule

module _regfile32 #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [4:0]   waddr,
    input  logic [n-1:0] wdata,
    input  logic [4:0]   raddr_a,
    input  logic [4:0]   raddr_b,
    output logic [n-1:0] rdata_a,
    output logic [n-1:0] rdata_b,
    input  logic         pend_set,
    input  logic [4:0]   pend_addr,
    output logic         pend_a,
    output logic         pend_b,
    output logic         stall
);

    logic [32*n-1:0] w_words;
    logic [31:0]     w_pend;
    logic [n-1:0]    w_mux_a;
    logic [n-1:0]    w_mux_b;
    logic            w_wr_ok;
    logic            w_hit_a;
    logic            w_hit_b;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                // Index 0 is hardwired: no storage, never pending.
                assign w_words[n-1:0] = '0;
                assign w_pend[0]      = 1'b0;
            end else begin : g_store
                logic [n-1:0] r_word;
                logic         r_pend;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_word <= '0;
                    end else if (we && (waddr == 5'(gi))) begin
                        r_word <= wdata;
                    end
                end

                // A new issue on the same edge as the retiring write keeps the bit set.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_pend <= 1'b0;
                    end else if (pend_set && (pend_addr == 5'(gi))) begin
                        r_pend <= 1'b1;
                    end else if (we && (waddr == 5'(gi))) begin
                        r_pend <= 1'b0;
                    end
                end

                assign w_words[gi*n +: n] = r_word;
                assign w_pend[gi]         = r_pend;
            end
        end
    endgenerate

    _mux32 #(.n(n)) u_mux_a (
        .i_data (w_words),
        .i_sel  (raddr_a),
        .o_data (w_mux_a)
    );

    _mux32 #(.n(n)) u_mux_b (
        .i_data (w_words),
        .i_sel  (raddr_b),
        .o_data (w_mux_b)
    );

    // Bypass is suppressed while reset is held so outputs read as zero throughout.
    assign w_wr_ok = rst_n && we && (waddr != 5'd0);
    assign w_hit_a = w_wr_ok && (waddr == raddr_a);
    assign w_hit_b = w_wr_ok && (waddr == raddr_b);

    assign rdata_a = w_hit_a ? wdata : w_mux_a;
    assign rdata_b = w_hit_b ? wdata : w_mux_b;
    assign pend_a  = w_pend[raddr_a] & ~w_hit_a;
    assign pend_b  = w_pend[raddr_b] & ~w_hit_b;
    assign stall   = pend_a | pend_b;

endmodule

// File: doc/_regfile32.md
Name: _regfile32

Overview:
32-entry general-purpose register file with two asynchronous read ports, one synchronous write port, and a per-register pending (scoreboard) bit. Sits directly upstream of the 32-input word multiplexers: the 32 storage words feed two _mux32 instances, one per read port, selected by the read addresses. Used by decode to fetch operands and by writeback to retire results. The scoreboard lets decode stall on operands whose producer has not yet written back.

Parameters:
n, constants::WORD_LENGTH, width of each register and of all data ports in bits

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
we  input  1  write enable for the writeback port
waddr  input  5  writeback destination register index
wdata  input  n  writeback data
raddr_a  input  5  read port A register index
raddr_b  input  5  read port B register index
rdata_a  output  n  read port A data (combinational)
rdata_b  output  n  read port B data (combinational)
pend_set  input  1  mark register pend_addr as pending (instruction issued with that destination)
pend_addr  input  5  register index to mark pending
pend_a  output  1  pending bit of raddr_a after bypass (combinational)
pend_b  output  1  pending bit of raddr_b after bypass (combinational)
stall  output  1  pend_a | pend_b

Behaviour:
- Reset (rst_n low, asynchronous): all 32 registers = 0; all 32 pending bits = 0. During and after reset: rdata_a = rdata_b = 0, pend_a = pend_b = 0, stall = 0. Reset asserted mid-write: the write is lost and the register stays 0.
- Register 0: always reads 0. Writes to index 0 are ignored. pend_set to index 0 is ignored, so pend for index 0 is always 0.
- Write: on the rising clk edge with we=1 and waddr!=0, reg[waddr] <= wdata. The pending bit for waddr is cleared on the same edge.
- Read: rdata_x = reg[raddr_x], selected through one _mux32 per port; zero-cycle latency.
- Write-through bypass: if we=1, waddr!=0 and waddr==raddr_x in the same cycle, rdata_x = wdata and pend_x = 0. Both ports bypass independently, including when raddr_a==raddr_b==waddr.
- Pending set: on the rising clk edge with pend_set=1 and pend_addr!=0, pend[pend_addr] <= 1.
- Set and clear on the same edge, same index (pend_set and we both targeting it): set wins, and the bit is 1 after the edge. This represents a new producer issuing as the old one retires. Bypass still applies to that cycle's reads.
- Set and clear on the same edge, different indices: both take effect.
- pend_x = pend[raddr_x] & ~(bypass hit on port x). Combinational only; no registered outputs besides storage.
- Setting an already-pending bit leaves it 1. Writing a non-pending register is legal and leaves the bit 0.
- No width conversion: wdata is stored unmodified. Index fields are 5 bits, so no out-of-range addresses exist.

Test Plan:
- Reset: hold rst_n=0, drive we=1 waddr=5 wdata=0xDEADBEEF for 3 clocks -> rdata_a (raddr_a=5) = 0 throughout. Release rst_n, idle one clock -> reg[5] still 0.
- Basic write/read: write 0x12345678 to r7, then 0xCAFEF00D to r31 on consecutive edges; raddr_a=7, raddr_b=31 -> rdata_a=0x12345678, rdata_b=0xCAFEF00D. Write 0xFFFFFFFF to r0 -> raddr_a=0 reads 0.
- Bypass: same cycle, we=1 waddr=9 wdata=0xA5A5A5A5 with raddr_a=raddr_b=9, where reg[9] held 0x1 -> both rdata = 0xA5A5A5A5 before the edge, and reg[9] = 0xA5A5A5A5 after it.
- Scoreboard: pend_set addr=3 -> next cycle raddr_a=3 gives pend_a=1, stall=1. Writeback we=1 waddr=3 -> pend_a=0 in the same cycle via bypass. After the edge, pend_a=0 and stall=0.
- Set/clear collision: r4 pending; same edge pend_set addr=4 and we waddr=4 wdata=0x55 -> after the edge reg[4]=0x55 and pend[4]=1 (raddr_b=4 gives pend_b=1). pend_set addr=0 -> pend for r0 stays 0.
- Async reset mid-operation: r10 pending with reg[10]=0x77; drop rst_n between clock edges -> pend, stall and rdata go to 0 immediately, without waiting for a clock edge.
